// File: rtl/acc_cpu.sv
// acc_cpu: multi-cycle accumulator core with a combinational-read program memory port.
// Optional carry flag and JC decode of opcode D are enabled by defining ACC_CPU_CARRY_EN.
module acc_cpu #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              halted,
    output logic [DATA_W-1:0] acc,
    output logic              flag_z,
    output logic              flag_c
);

    typedef enum logic [2:0] {S_FETCH, S_EX1, S_EX2, S_OUTW, S_HALT} state_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
        OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_MOV = 4'h7,
        OP_NOT = 4'h8, OP_PSB = 4'h9, OP_INC = 4'hA, OP_LDW = 4'hB,
        OP_JMP = 4'hC, OP_JZ  = 4'hD, OP_OUT = 4'hE, OP_HLT = 4'hF
    } opcode_e;

    state_e            state;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] regs [8];
    logic [7:0]        reg_exists;
    opcode_e           fetch_op;
    opcode_e           ir_op;
    logic [2:0]        ridx;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] low_ext;
    logic [DATA_W-1:0] alu_y;
    logic              jz_take;

    assign imem_addr = pc;
    assign acc       = a;
    assign fetch_op  = opcode_e'(imem_rdata[7:4]);
    assign ir_op     = opcode_e'(ir[7:4]);
    assign ridx      = ir[2:0];
    assign low_ext   = DATA_W'(ir[3:0]);

    // Slot 0 and slots at or above NREGS read as zero and ignore writes.
    always_comb begin
        reg_exists = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            reg_exists[i] = (i < NREGS);
        end
    end

    assign rd_val = reg_exists[ridx] ? regs[ridx] : '0;

    always_comb begin
        case (ir_op)
            OP_ADD:  alu_y = a + b;
            OP_SUB:  alu_y = a - b;
            OP_AND:  alu_y = a & b;
            OP_OR:   alu_y = a | b;
            OP_XOR:  alu_y = a ^ b;
            OP_NOT:  alu_y = ~a;
            OP_PSB:  alu_y = b;
            OP_INC:  alu_y = a + DATA_W'(1);
            default: alu_y = a;
        endcase
    end

`ifdef ACC_CPU_CARRY_EN
    logic carry_q;
    logic alu_c;

    // Carry-out of a modular add shows up as the sum wrapping below an operand.
    always_comb begin
        case (ir_op)
            OP_ADD:  alu_c = (alu_y < a);
            OP_SUB:  alu_c = (a < b);
            OP_INC:  alu_c = (a == '1);
            default: alu_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_q <= 1'b0;
        end else if (state == S_EX2) begin
            carry_q <= alu_c;
        end
    end

    assign flag_c  = carry_q;
    assign jz_take = ir[3] ? carry_q : flag_z;
`else
    assign flag_c  = 1'b0;
    assign jz_take = flag_z;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            pc        <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            flag_z    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            halted    <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    ir <= imem_rdata[7:0];
                    case (fetch_op)
                        OP_HLT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        OP_OUT: begin
                            pc        <= pc + ADDR_W'(1);
                            out_valid <= 1'b1;
                            out_data  <= a;
                            state     <= S_OUTW;
                        end
                        default: begin
                            pc    <= pc + ADDR_W'(1);
                            state <= S_EX1;
                        end
                    endcase
                end
                S_EX1: begin
                    state <= S_FETCH;
                    case (ir_op)
                        OP_LDI: begin
                            a      <= low_ext;
                            flag_z <= (ir[3:0] == 4'h0);
                        end
                        OP_MOV: begin
                            if (reg_exists[ridx]) begin
                                regs[ridx] <= a;
                            end
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_PSB, OP_INC: begin
                            b     <= rd_val;
                            state <= S_EX2;
                        end
                        OP_LDW: begin
                            a      <= imem_rdata;
                            flag_z <= (imem_rdata == '0);
                            pc     <= pc + ADDR_W'(1);
                        end
                        OP_JMP: pc <= imem_rdata[ADDR_W-1:0];
                        OP_JZ:  pc <= jz_take ? imem_rdata[ADDR_W-1:0] : pc + ADDR_W'(1);
                        default: ;
                    endcase
                end
                S_EX2: begin
                    a      <= alu_y;
                    flag_z <= (alu_y == '0);
                    state  <= S_FETCH;
                end
                S_OUTW: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                S_HALT: ;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_cpu.sv
// Directed self-checking bench for acc_cpu: default instance plus a small ADDR_W=4/NREGS=4 instance.
// Carry expectations follow ACC_CPU_CARRY_EN when the bench is built with it.
module tb_acc_cpu;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       halted;
    logic [7:0] acc;
    logic       flag_z;
    logic       flag_c;

    logic       reset_s;
    logic [3:0] imem_addr_s;
    logic [7:0] imem_rdata_s;
    logic       out_valid_s;
    logic [7:0] out_data_s;
    logic       halted_s;
    logic [7:0] acc_s;
    logic       flag_z_s;
    logic       flag_c_s;

    logic [7:0] mem   [256];
    logic [7:0] mem_s [16];
    logic [7:0] outs [$];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign imem_rdata   = mem[imem_addr];
    assign imem_rdata_s = mem_s[imem_addr_s];

    acc_cpu u_dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .halted     (halted),
        .acc        (acc),
        .flag_z     (flag_z),
        .flag_c     (flag_c)
    );

    acc_cpu #(.DATA_W(8), .ADDR_W(4), .NREGS(4)) u_small (
        .clk        (clk),
        .reset      (reset_s),
        .imem_addr  (imem_addr_s),
        .imem_rdata (imem_rdata_s),
        .out_valid  (out_valid_s),
        .out_data   (out_data_s),
        .out_ready  (1'b1),
        .halted     (halted_s),
        .acc        (acc_s),
        .flag_z     (flag_z_s),
        .flag_c     (flag_c_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_prog(input logic [7:0] prog[$]);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
    endtask

    // Reset released on a negedge so the next posedge is the first fetch.
    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_prog(input int max_cyc, output int halt_cyc, output int out_cyc);
        halt_cyc = -1;
        out_cyc  = -1;
        outs.delete();
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                outs.push_back(out_data);
                if (out_cyc < 0) out_cyc = i;
            end
            if (halted) begin
                halt_cyc = i;
                break;
            end
        end
        if (halt_cyc < 0) check_eq("halt_timeout", 32'(halted), 1);
    endtask

    initial begin
        logic [7:0] p[$];
        logic [7:0] exp_outs[$];
        int hc;
        int oc;
        int exp_c;

        reset     = 1'b0;
        reset_s   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem_s[i] = 8'h00;

        // Reset state
        p = '{8'h15, 8'h71, 8'h13, 8'h21, 8'hE0, 8'hF0};
        load_prog(p);
        #1;
        check_eq("rst_acc",    32'(acc), 0);
        check_eq("rst_addr",   32'(imem_addr), 0);
        check_eq("rst_valid",  32'(out_valid), 0);
        check_eq("rst_data",   32'(out_data), 0);
        check_eq("rst_halted", 32'(halted), 0);
        check_eq("rst_z",      32'(flag_z), 0);
        check_eq("rst_c",      32'(flag_c), 0);

        // Basic program: 5 -> R1, 3 + R1 -> OUT 8 -> HLT at 5
        do_reset();
        run_prog(40, hc, oc);
        check_eq("p1_out_cnt",  32'(outs.size()), 1);
        if (outs.size() > 0) check_eq("p1_out_data", 32'(outs[0]), 8);
        check_eq("p1_out_cyc",  32'(oc), 10);
        check_eq("p1_halt_cyc", 32'(hc), 12);
        check_eq("p1_addr",     32'(imem_addr), 5);
        repeat (3) @(negedge clk);
        check_eq("p1_hold_addr", 32'(imem_addr), 5);
        check_eq("p1_hold_acc",  32'(acc), 8);
        check_eq("p1_hold_hlt",  32'(halted), 1);
        check_eq("p1_z",         32'(flag_z), 0);

        // ALU sweep through OUT after each op
        p = '{8'h16, 8'h72, 8'h13, 8'h73, 8'h32, 8'hE0, 8'h63, 8'hE0, 8'h80, 8'hE0,
              8'h52, 8'hE0, 8'h43, 8'hE0, 8'h92, 8'hE0, 8'hF0};
        exp_outs = '{8'hFD, 8'hFE, 8'h01, 8'h07, 8'h03, 8'h06};
        load_prog(p);
        do_reset();
        run_prog(100, hc, oc);
        check_eq("alu_out_cnt", 32'(outs.size()), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < outs.size()) check_eq($sformatf("alu_out%0d", i), 32'(outs[i]), 32'(exp_outs[i]));
        end

        // LDW 0xFF; INC -> wrap to zero
        p = '{8'hB0, 8'hFF, 8'hA0, 8'hF0};
        load_prog(p);
        do_reset();
        run_prog(40, hc, oc);
`ifdef ACC_CPU_CARRY_EN
        exp_c = 1;
`else
        exp_c = 0;
`endif
        check_eq("inc_acc", 32'(acc), 0);
        check_eq("inc_z",   32'(flag_z), 1);
        check_eq("inc_c",   32'(flag_c), 32'(exp_c));

        // JZ taken
        p = '{8'h10, 8'hD0, 8'h20};
        load_prog(p);
        mem[8'h20] = 8'hF0;
        do_reset();
        repeat (4) @(negedge clk);
        check_eq("jz_t_addr", 32'(imem_addr), 32'h20);
        run_prog(20, hc, oc);
        check_eq("jz_t_halt", 32'(imem_addr), 32'h20);

        // JZ not taken
        p = '{8'h11, 8'hD0, 8'h20, 8'hF0};
        load_prog(p);
        mem[8'h20] = 8'hF0;
        do_reset();
        repeat (4) @(negedge clk);
        check_eq("jz_n_addr", 32'(imem_addr), 3);
        run_prog(20, hc, oc);
        check_eq("jz_n_halt", 32'(imem_addr), 3);

        // OUT backpressure
        p = '{8'h19, 8'hE0, 8'h12, 8'hF0};
        load_prog(p);
        out_ready = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("stall_valid%0d", k), 32'(out_valid), 1);
            check_eq($sformatf("stall_data%0d", k),  32'(out_data), 9);
            check_eq($sformatf("stall_addr%0d", k),  32'(imem_addr), 2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("xfer_valid", 32'(out_valid), 0);
        check_eq("xfer_addr",  32'(imem_addr), 2);
        @(negedge clk);
        check_eq("resume_addr", 32'(imem_addr), 3);
        run_prog(20, hc, oc);
        check_eq("resume_acc", 32'(acc), 2);

        // Reset mid-EX1 of ADD
        p = '{8'h15, 8'h71, 8'h13, 8'h21, 8'hE0, 8'hF0};
        load_prog(p);
        do_reset();
        repeat (7) @(negedge clk);
        check_eq("pre_rst_acc", 32'(acc), 3);
        reset = 1'b0;
        #1;
        check_eq("mrst_acc",    32'(acc), 0);
        check_eq("mrst_addr",   32'(imem_addr), 0);
        check_eq("mrst_valid",  32'(out_valid), 0);
        check_eq("mrst_data",   32'(out_data), 0);
        check_eq("mrst_halted", 32'(halted), 0);
        check_eq("mrst_z",      32'(flag_z), 0);
        check_eq("mrst_c",      32'(flag_c), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_addr", 32'(imem_addr), 1);
        @(negedge clk);
        check_eq("post_rst_acc", 32'(acc), 5);

        // Small instance: PC wrap with sixteen NOPs
        reset_s = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 30) check_eq("wrap_addr15", 32'(imem_addr_s), 15);
            if (i == 32) check_eq("wrap_addr0",  32'(imem_addr_s), 0);
        end

        // Small instance: R5 absent, R3 present
        reset_s = 1'b0;
        mem_s[0] = 8'h13; mem_s[1] = 8'h73; mem_s[2] = 8'h75;
        mem_s[3] = 8'h25; mem_s[4] = 8'h23; mem_s[5] = 8'hF0;
        repeat (2) @(negedge clk);
        reset_s = 1'b1;
        repeat (9) @(negedge clk);
        check_eq("small_r5_acc", 32'(acc_s), 3);
        for (int i = 0; i < 40 && !halted_s; i++) @(negedge clk);
        check_eq("small_halt",   32'(halted_s), 1);
        check_eq("small_r3_acc", 32'(acc_s), 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
